// File: rtl/pid_loop_sequencer.sv
// pid_loop_sequencer
//   Runs one pid_controller at a fixed control rate. Each control period it
//   consumes the latest sensor sample, forms error = setpoint - measurement
//   (saturated to 32 bits), strobes it into the PID, waits for the PID
//   command and applies it to the motor. It also supervises the PID:
//   response timeout, stale sensor data and period overruns. Any of the
//   first two lands in a sticky FAULT that zeroes the command and holds the
//   PID cleared until enable drops.
//
// Optional build macro:
//   PID_SEQ_DEADBAND_EN - errors with |error| <= DEADBAND are sent as 0.
//                         When undefined the error passes unmodified.
//
// Ports:
//   clk             in   system clock
//   rst             in   synchronous active-high reset
//   enable          in   loop run; low = idle, clears fault
//   setpoint        in   signed target
//   meas_data       in   signed sensor value
//   meas_valid      in   one-cycle sample strobe
//   pid_error       out  signed error to PID (registered, held until next strobe)
//   pid_error_ready out  one-cycle strobe to PID
//   pid_clear       out  drives PID reset
//   pid_cmd_valid   in   PID command valid
//   pid_output      in   signed PID command
//   cmd_out         out  signed applied motor command
//   cmd_out_valid   out  one-cycle pulse when cmd_out takes a PID command
//   overrun         out  one-cycle pulse: period tick arrived while busy
//   fault           out  sticky fault level, cleared by enable low
//   busy            out  high while a PID transaction is in flight
module pid_loop_sequencer #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned RESP_TIMEOUT = 8,
  parameter int unsigned STALE_LIMIT  = 3,
  parameter int unsigned DEADBAND     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic signed [31:0] setpoint,
  input  logic signed [31:0] meas_data,
  input  logic               meas_valid,
  output logic signed [31:0] pid_error,
  output logic               pid_error_ready,
  output logic               pid_clear,
  input  logic               pid_cmd_valid,
  input  logic signed [31:0] pid_output,
  output logic signed [31:0] cmd_out,
  output logic               cmd_out_valid,
  output logic               overrun,
  output logic               fault,
  output logic               busy
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned WW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam int unsigned SW = (STALE_LIMIT > 1) ? $clog2(STALE_LIMIT) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(RESP_TIMEOUT - 1);
  localparam logic [SW-1:0] STALE_LAST = SW'(STALE_LIMIT - 1);

`ifdef PID_SEQ_DEADBAND_EN
  localparam bit DB_ON = 1'b1;
`else
  localparam bit DB_ON = 1'b0;
`endif
  localparam logic signed [31:0] DB_POS = 32'(DEADBAND);
  localparam logic signed [31:0] DB_NEG = -DB_POS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_ISSUE,
    S_WAIT_RESP,
    S_FAULT
  } state_e;

  state_e             state_q, state_d;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic [WW-1:0]      wait_q, wait_d;
  logic [SW-1:0]      stale_q, stale_d;
  logic               fresh_q, fresh_d;
  logic signed [31:0] meas_q, meas_d;
  logic signed [31:0] err_q, err_d;
  logic signed [31:0] cmd_q, cmd_d;
  logic               cmd_vld_q, cmd_vld_d;
  logic               ovr_q, ovr_d;

  logic               counting;
  logic               tick;
  logic               consume;
  logic signed [32:0] diff;
  logic signed [31:0] sat;
  logic               db_hit;
  logic signed [31:0] err_calc;

  // Error datapath: 33-bit difference cannot overflow; clamp back to 32 bits.
  always_comb begin
    diff = {setpoint[31], setpoint} - {meas_q[31], meas_q};
    if (diff[32] != diff[31]) begin
      sat = diff[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end else begin
      sat = diff[31:0];
    end
    db_hit   = DB_ON && (sat >= DB_NEG) && (sat <= DB_POS);
    err_calc = db_hit ? '0 : sat;
  end

  // The period counter runs only while the loop is active (not idle/fault).
  always_comb begin
    counting = enable && ((state_q == S_RUN) || (state_q == S_ISSUE) ||
                          (state_q == S_WAIT_RESP));
    tick     = counting && (tick_cnt_q == TICK_LAST);
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    stale_d   = stale_q;
    err_d     = err_q;
    cmd_d     = cmd_q;
    cmd_vld_d = 1'b0;
    ovr_d     = 1'b0;
    consume   = 1'b0;

    if (!enable) begin
      // Dropping enable wins over any tick or response at the same edge.
      state_d = S_IDLE;
      stale_d = '0;
      wait_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_RUN;
        end
        S_RUN: begin
          if (tick) begin
            if (fresh_q) begin
              err_d   = err_calc;
              stale_d = '0;
              consume = 1'b1;
              state_d = S_ISSUE;
            end else if (stale_q == STALE_LAST) begin
              state_d = S_FAULT;
            end else begin
              stale_d = stale_q + SW'(1);
            end
          end
        end
        S_ISSUE: begin
          ovr_d   = tick;
          wait_d  = '0;
          state_d = S_WAIT_RESP;
        end
        S_WAIT_RESP: begin
          ovr_d = tick;
          if (pid_cmd_valid) begin
            cmd_d     = pid_output;
            cmd_vld_d = 1'b1;
            state_d   = S_RUN;
          end else if (wait_q == WAIT_LAST) begin
            state_d = S_FAULT;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // The motor command is forced to zero whenever the loop is not running.
    if ((state_d == S_IDLE) || (state_d == S_FAULT)) begin
      cmd_d = '0;
    end

    // Counter restarts from 0 each time the loop (re)enters RUN.
    if ((state_d == S_IDLE) || (state_d == S_FAULT) || !counting || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end

    // A new sample arriving on the consuming tick keeps fresh set.
    meas_d  = meas_valid ? meas_data : meas_q;
    fresh_d = meas_valid ? 1'b1 : (consume ? 1'b0 : fresh_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      wait_q     <= '0;
      stale_q    <= '0;
      fresh_q    <= 1'b0;
      meas_q     <= '0;
      err_q      <= '0;
      cmd_q      <= '0;
      cmd_vld_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      wait_q     <= wait_d;
      stale_q    <= stale_d;
      fresh_q    <= fresh_d;
      meas_q     <= meas_d;
      err_q      <= err_d;
      cmd_q      <= cmd_d;
      cmd_vld_q  <= cmd_vld_d;
      ovr_q      <= ovr_d;
    end
  end

  assign pid_error       = err_q;
  assign pid_error_ready = (state_q == S_ISSUE);
  assign pid_clear       = (state_q == S_IDLE) || (state_q == S_FAULT);
  assign cmd_out         = cmd_q;
  assign cmd_out_valid   = cmd_vld_q;
  assign overrun         = ovr_q;
  assign fault           = (state_q == S_FAULT);
  assign busy            = (state_q == S_ISSUE) || (state_q == S_WAIT_RESP);

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Self-checking bench for pid_loop_sequencer: directed scenarios followed by
// randomized traffic, all compared every cycle against a transaction-level
// reference model (elapsed-cycle arithmetic, not a state machine copy).
module tb_pid_loop_sequencer;

  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned RESP_TIMEOUT = 8;
  localparam int unsigned STALE_LIMIT  = 3;
  localparam int unsigned DEADBAND     = 2;
  localparam longint      DB           = DEADBAND;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [31:0] setpoint;
  logic signed [31:0] meas_data;
  logic               meas_valid;
  logic signed [31:0] pid_error;
  logic               pid_error_ready;
  logic               pid_clear;
  logic               pid_cmd_valid;
  logic signed [31:0] pid_output;
  logic signed [31:0] cmd_out;
  logic               cmd_out_valid;
  logic               overrun;
  logic               fault;
  logic               busy;

  always #5 clk = ~clk;

  pid_loop_sequencer #(
    .TICK_DIV    (TICK_DIV),
    .RESP_TIMEOUT(RESP_TIMEOUT),
    .STALE_LIMIT (STALE_LIMIT),
    .DEADBAND    (DEADBAND)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .setpoint       (setpoint),
    .meas_data      (meas_data),
    .meas_valid     (meas_valid),
    .pid_error      (pid_error),
    .pid_error_ready(pid_error_ready),
    .pid_clear      (pid_clear),
    .pid_cmd_valid  (pid_cmd_valid),
    .pid_output     (pid_output),
    .cmd_out        (cmd_out),
    .cmd_out_valid  (cmd_out_valid),
    .overrun        (overrun),
    .fault          (fault),
    .busy           (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: loop is "running" (not idle, not faulted), a PID
  // transaction is "in flight" with a count of cycles since the strobe.
  bit          m_running, m_fault, m_inflight, m_fresh, m_cmdv, m_ovr;
  int          m_phase, m_since, m_stale;
  logic [31:0] m_err, m_cmd, m_meas;

  task automatic model_fault();
    m_fault    = 1;
    m_running  = 0;
    m_inflight = 0;
    m_cmd      = '0;
    m_phase    = 0;
  endtask

  task automatic model_step();
    bit     tk, consumed;
    longint d;
    consumed = 0;
    m_cmdv   = 0;
    m_ovr    = 0;
    if (rst) begin
      m_running = 0; m_fault = 0; m_inflight = 0; m_fresh = 0;
      m_phase = 0; m_since = 0; m_stale = 0;
      m_err = '0; m_cmd = '0; m_meas = '0;
      return;
    end
    tk = m_running && ((m_phase % TICK_DIV) == TICK_DIV - 1);
    if (!enable) begin
      m_running = 0; m_fault = 0; m_inflight = 0; m_stale = 0;
      m_cmd = '0; m_phase = 0;
    end else if (m_fault) begin
      m_phase = 0;
    end else if (!m_running) begin
      m_running = 1;
      m_phase   = 0;
    end else begin
      m_phase++;
      if (m_inflight) begin
        if (tk) m_ovr = 1;
        if (m_since >= 1 && pid_cmd_valid) begin
          m_cmd      = pid_output;
          m_cmdv     = 1;
          m_inflight = 0;
        end else if (m_since >= RESP_TIMEOUT) begin
          model_fault();
        end else begin
          m_since++;
        end
      end else if (tk) begin
        if (m_fresh) begin
          d = longint'($signed(setpoint)) - longint'($signed(m_meas));
          if (d > 64'sd2147483647) d = 64'sd2147483647;
          if (d < -64'sd2147483648) d = -64'sd2147483648;
`ifdef PID_SEQ_DEADBAND_EN
          if (d >= -DB && d <= DB) d = 0;
`endif
          m_err      = d[31:0];
          m_inflight = 1;
          m_since    = 0;
          m_stale    = 0;
          consumed   = 1;
        end else begin
          m_stale++;
          if (m_stale >= STALE_LIMIT) model_fault();
        end
      end
    end
    if (meas_valid) begin
      m_fresh = 1;
      m_meas  = meas_data;
    end else if (consumed) begin
      m_fresh = 0;
    end
  endtask

  task automatic check_all();
    check("pid_error",       pid_error,       m_err);
    check("pid_error_ready", pid_error_ready, 32'(m_inflight && m_since == 0));
    check("pid_clear",       pid_clear,       32'(!m_running));
    check("cmd_out",         cmd_out,         m_cmd);
    check("cmd_out_valid",   cmd_out_valid,   32'(m_cmdv));
    check("overrun",         overrun,         32'(m_ovr));
    check("fault",           fault,           32'(m_fault));
    check("busy",            busy,            32'(m_inflight));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run_to_issue(input int max_cycles);
    int n = 0;
    while (!(m_inflight && m_since == 0) && n < max_cycles) begin
      step();
      n++;
    end
    check("reach_issue", pid_error_ready, 1);
  endtask

  task automatic sample(input logic [31:0] sp, input logic [31:0] md);
    setpoint   = sp;
    meas_data  = md;
    meas_valid = 1'b1;
    step();
    meas_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0:       v = $urandom;
      1:       v = 32'($urandom_range(0, 8)) - 32'd4;
      2:       v = 32'h7FFF_FFFF;
      3:       v = 32'h8000_0000;
      default: v = 32'($urandom_range(0, 200));
    endcase
    return v;
  endfunction

  initial begin
    int ovr_seen;
    int n;
    int en_hold;
    int p_meas;
    int p_cv;

    rst = 1'b1; enable = 1'b0; setpoint = '0; meas_data = '0;
    meas_valid = 1'b0; pid_cmd_valid = 1'b0; pid_output = '0;

    // Reset state
    step();
    step();
    check("rst_pid_clear", pid_clear, 1);
    check("rst_cmd_out", cmd_out, 0);
    check("rst_fault", fault, 0);

    // Basic loop
    rst = 1'b0; enable = 1'b1;
    pid_cmd_valid = 1'b1; pid_output = 32'd3;
    sample(32'd100, 32'd40);
    run_to_issue(20);
    check("basic_err", pid_error, 32'd60);
    step();
    step();
    check("basic_cmd", cmd_out, 32'd3);
    check("basic_cmd_valid", cmd_out_valid, 1);

    // Saturation both ways
    sample(32'h7FFF_FFFF, -32'sd5);
    run_to_issue(20);
    check("sat_pos", pid_error, 32'h7FFF_FFFF);
    step(); step();
    sample(32'h8000_0000, 32'd1);
    run_to_issue(20);
    check("sat_neg", pid_error, 32'h8000_0000);
    step(); step();

    // Response timeout
    pid_cmd_valid = 1'b0;
    sample(32'd10, 32'd4);
    run_to_issue(20);
    repeat (RESP_TIMEOUT + 1) step();
    check("to_fault", fault, 1);
    check("to_cmd_zero", cmd_out, 0);
    check("to_pid_clear", pid_clear, 1);
    enable = 1'b0;
    step();
    check("to_idle_fault", fault, 0);
    check("to_idle_clear", pid_clear, 1);
    enable = 1'b1;
    step();
    check("to_run_clear", pid_clear, 0);

    // Stale data: command held for two empty ticks, fault on the third
    pid_cmd_valid = 1'b1; pid_output = 32'd7;
    sample(32'd20, 32'd5);
    run_to_issue(20);
    step(); step();
    pid_cmd_valid = 1'b0;
    n = 0;
    while (m_stale < STALE_LIMIT - 1 && n < 50) begin step(); n++; end
    check("stale_hold", cmd_out, 32'd7);
    check("stale_nofault", fault, 0);
    n = 0;
    while (!m_fault && n < 50) begin step(); n++; end
    check("stale_fault", fault, 1);
    check("stale_cmd_zero", cmd_out, 0);

    // Overrun: response 5 cycles after the strobe spans one tick
    enable = 1'b0;
    step();
    enable = 1'b1;
    sample(32'd30, 32'd10);
    run_to_issue(20);
    ovr_seen = 0;
    pid_output = 32'd11;
    for (int k = 1; k <= 6; k++) begin
      pid_cmd_valid = (k == 5);
      step();
      if (overrun === 1'b1) ovr_seen++;
      if (k == 5) check("ovr_cmd", cmd_out, 32'd11);
    end
    check("ovr_count", 32'(ovr_seen), 1);

    // Reset while waiting for the PID
    pid_cmd_valid = 1'b0;
    sample(32'd1, 32'd2);
    run_to_issue(20);
    step();
    check("rstw_busy_before", busy, 1);
    rst = 1'b1;
    step();
    check("rstw_clear", pid_clear, 1);
    check("rstw_busy", busy, 0);
    check("rstw_err", pid_error, 0);
    rst = 1'b0;

    // Deadband edge
    pid_cmd_valid = 1'b1; pid_output = 32'd1;
    sample(32'd50, 32'd48);
    run_to_issue(20);
`ifdef PID_SEQ_DEADBAND_EN
    check("db_inside", pid_error, 32'd0);
`else
    check("db_inside", pid_error, 32'd2);
`endif
    step(); step();
    sample(32'd50, 32'd47);
    run_to_issue(20);
    check("db_outside", pid_error, 32'd3);
    step(); step();

    // Randomized traffic
    en_hold = 0;
    for (int seg = 0; seg < 15; seg++) begin
      case ($urandom_range(0, 2))
        0: p_meas = 10;
        1: p_meas = 40;
        default: p_meas = 90;
      endcase
      case ($urandom_range(0, 2))
        0: p_cv = 5;
        1: p_cv = 50;
        default: p_cv = 95;
      endcase
      for (int c = 0; c < 200; c++) begin
        rst = ($urandom_range(0, 299) == 0);
        if (en_hold > 0) begin
          en_hold--;
          enable = 1'b0;
        end else if ($urandom_range(0, 99) < 2) begin
          en_hold = $urandom_range(0, 3);
          enable  = 1'b0;
        end else begin
          enable = 1'b1;
        end
        meas_valid = ($urandom_range(0, 99) < p_meas);
        meas_data  = rand_val();
        if ($urandom_range(0, 4) == 0) setpoint = rand_val();
        pid_cmd_valid = ($urandom_range(0, 99) < p_cv);
        pid_output    = $urandom;
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
